// File: rtl/rothr_pipe.sv
// rtl/rothr_pipe.sv - two-stage halfword rotate/shift-right execute unit
module rothr_pipe #(
  parameter int LANES = 8,
  parameter int TAGW  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [1:0]            in_op,
  input  logic                  in_use_imm,
  input  logic [6:0]            in_imme7,
  input  logic [16*LANES-1:0]   in_ra,
  input  logic [16*LANES-1:0]   in_rb,
  input  logic [TAGW-1:0]       in_rt_addr,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [16*LANES-1:0]   out_result,
  output logic [TAGW-1:0]       out_rt_addr,
  output logic                  out_illegal
);

  localparam int W = 16 * LANES;

  localparam logic [1:0] OP_ROTHR  = 2'b00;
  localparam logic [1:0] OP_ROTHM  = 2'b01;
  localparam logic [1:0] OP_ROTMAH = 2'b10;
  localparam logic [1:0] OP_ILL    = 2'b11;

  // Lane 0 is the most significant halfword (bit 0 = MSB numbering).
  // Only the low 5 bits of each amount matter: rotate uses 4, shifts use a 5-bit negate.
  logic [LANES-1:0][4:0] raw;
  logic [LANES-1:0][4:0] amt_d;

  logic                  s1_valid;
  logic [1:0]            s1_op;
  logic [W-1:0]          s1_ra;
  logic [TAGW-1:0]       s1_tag;
  logic [LANES-1:0][4:0] s1_amt;

  logic [W-1:0]          res_d;

  // Upper amount bits are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^{in_imme7[6:5], in_rb};

  // One lane of the execute stage; a[4] set means the shift count is 16 or more.
  function automatic logic [15:0] lane_op(input logic [1:0] op, input logic [15:0] t,
                                          input logic [4:0] a);
    logic [15:0] res;
    res = 16'h0000;
    case (op)
      OP_ROTHR:  res = (t >> a[3:0]) | (t << (5'd16 - {1'b0, a[3:0]}));
      OP_ROTHM:  res = a[4] ? 16'h0000 : (t >> a[3:0]);
      OP_ROTMAH: res = a[4] ? {16{t[15]}} : $unsigned($signed(t) >>> a[3:0]);
      default:   res = 16'h0000;
    endcase
    return res;
  endfunction

  // Per-lane amount: rotate count for ROTHR, negated 5-bit shift count for the shifts
  always_comb begin
    raw   = '0;
    amt_d = '0;
    for (int j = 0; j < LANES; j++) begin
      raw[j]   = in_use_imm ? in_imme7[4:0] : in_rb[W-12-16*j -: 5];
      amt_d[j] = (in_op == OP_ROTHR) ? {1'b0, raw[j][3:0]} : (5'd0 - raw[j]);
    end
  end

  // S1 register: capture operand, tag and precomputed amounts; flush beats stall on valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_ra    <= '0;
      s1_tag   <= '0;
      s1_amt   <= '0;
    end else begin
      if (flush) begin
        s1_valid <= 1'b0;
      end else if (!stall) begin
        s1_valid <= in_valid;
      end
      if (!stall) begin
        s1_op  <= in_op;
        s1_ra  <= in_ra;
        s1_tag <= in_rt_addr;
        s1_amt <= amt_d;
      end
    end
  end

  // S2 datapath: apply rotate/shift to every lane
  always_comb begin
    res_d = '0;
    for (int j = 0; j < LANES; j++) begin
      res_d[W-1-16*j -: 16] = lane_op(s1_op, s1_ra[W-1-16*j -: 16], s1_amt[j]);
    end
  end

  // Output register: result, tag and illegal flag; flush beats stall on valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_rt_addr <= '0;
      out_illegal <= 1'b0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (!stall) begin
        out_valid <= s1_valid;
      end
      if (!stall) begin
        out_result  <= res_d;
        out_rt_addr <= s1_tag;
        out_illegal <= s1_valid & (s1_op == OP_ILL);
      end
    end
  end

endmodule

// File: tb/tb_rothr_pipe.sv
// tb/tb_rothr_pipe.sv - scoreboard bench for rothr_pipe
module tb_rothr_pipe;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [1:0]   in_op;
  logic         in_use_imm;
  logic [6:0]   in_imme7;
  logic [127:0] in_ra;
  logic [127:0] in_rb;
  logic [6:0]   in_rt_addr;
  logic         stall;
  logic         flush;
  logic         out_valid;
  logic [127:0] out_result;
  logic [6:0]   out_rt_addr;
  logic         out_illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [6:0]   tag;
    logic [127:0] res;
    logic         ill;
  } exp_t;

  exp_t sbq[$];

  rothr_pipe #(.LANES(8), .TAGW(7)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_op       (in_op),
    .in_use_imm  (in_use_imm),
    .in_imme7    (in_imme7),
    .in_ra       (in_ra),
    .in_rb       (in_rb),
    .in_rt_addr  (in_rt_addr),
    .stall       (stall),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_result  (out_result),
    .out_rt_addr (out_rt_addr),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: bit-level, MSB-first lane numbering as in the architecture text
  function automatic logic [127:0] model(input logic [1:0] op, input logic use_imm,
                                         input logic [6:0] imm, input logic [127:0] ra,
                                         input logic [127:0] rb);
    logic [127:0] res;
    logic [15:0]  t;
    logic [6:0]   rawv;
    int           r;
    int           c;
    logic         bv;
    res = '0;
    for (int j = 0; j < 8; j++) begin
      t    = ra[127-16*j -: 16];
      rawv = use_imm ? imm : rb[118-16*j -: 7];
      r    = int'(rawv) % 16;
      c    = (32 - (int'(rawv) % 32)) % 32;
      for (int b = 0; b < 16; b++) begin
        case (op)
          2'b00:   bv = t[15 - ((b - r + 16) % 16)];
          2'b01:   bv = (c < 16 && b >= c) ? t[15 - (b - c)] : 1'b0;
          2'b10:   bv = (c < 16 && b >= c) ? t[15 - (b - c)] : t[15];
          default: bv = 1'b0;
        endcase
        res[127-16*j-b] = bv;
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic use_imm, input logic [6:0] imm,
                       input logic [127:0] ra, input logic [127:0] rb, input logic [6:0] tag);
    in_valid   = 1'b1;
    in_op      = op;
    in_use_imm = use_imm;
    in_imme7   = imm;
    in_ra      = ra;
    in_rb      = rb;
    in_rt_addr = tag;
  endtask

  // Present one op for one edge (caller guarantees stall = flush = 0) and record its result
  task automatic issue(input logic [1:0] op, input logic use_imm, input logic [6:0] imm,
                       input logic [127:0] ra, input logic [127:0] rb, input logic [6:0] tag,
                       input logic [127:0] exp);
    exp_t e;
    drive(op, use_imm, imm, ra, rb, tag);
    @(posedge clk);
    e.tag = tag;
    e.res = exp;
    e.ill = (op == 2'b11);
    sbq.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: an output is consumed on a cycle where it is valid and the pipe advances
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && !stall) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output tag=%0d result=%h (no op outstanding)", out_rt_addr, out_result);
      end else begin
        e = sbq.pop_front();
        if (out_rt_addr !== e.tag || out_result !== e.res || out_illegal !== e.ill) begin
          bad++;
          $display("FAIL scoreboard tag got=%0d exp=%0d result got=%h exp=%h illegal got=%b exp=%b",
                   out_rt_addr, e.tag, out_result, e.res, out_illegal, e.ill);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [127:0] ra8001, ra8000, ra7fff, ra8f00, rbreg, zero;
    ra8001 = {8{16'h8001}};
    ra8000 = {8{16'h8000}};
    ra7fff = {8{16'h7FFF}};
    ra8f00 = {8{16'h8F00}};
    zero   = '0;
    rbreg  = '0;
    for (int j = 0; j < 8; j++) rbreg[127-16*j -: 16] = 16'hAB80 | (16'h007F - 16'(j));

    rst = 1'b1;
    in_valid = 1'b0; in_op = 2'b00; in_use_imm = 1'b0; in_imme7 = '0;
    in_ra = '0; in_rb = '0; in_rt_addr = '0; stall = 1'b0; flush = 1'b0;
    #12;
    check("reset_valid",   {127'd0, out_valid},   128'd0);
    check("reset_result",  out_result,            128'd0);
    check("reset_tag",     {121'd0, out_rt_addr}, 128'd0);
    check("reset_illegal", {127'd0, out_illegal}, 128'd0);
    rst = 1'b0;

    // Immediate-mode hand vectors, back to back
    issue(2'b00, 1'b1, 7'h01, ra8001, zero, 7'd1,  {8{16'hC000}});
    issue(2'b00, 1'b1, 7'h10, ra8001, zero, 7'd2,  ra8001);
    issue(2'b00, 1'b1, 7'h7F, ra8001, zero, 7'd3,  {8{16'h0003}});
    issue(2'b01, 1'b1, 7'h7F, ra8000, zero, 7'd4,  {8{16'h4000}});
    issue(2'b01, 1'b1, 7'h70, ra8000, zero, 7'd5,  {8{16'h0000}});
    issue(2'b01, 1'b1, 7'h00, ra8000, zero, 7'd6,  ra8000);
    issue(2'b10, 1'b1, 7'h7F, ra8000, zero, 7'd7,  {8{16'hC000}});
    issue(2'b10, 1'b1, 7'h70, ra8000, zero, 7'd8,  {8{16'hFFFF}});
    issue(2'b10, 1'b1, 7'h70, ra7fff, zero, 7'd9,  {8{16'h0000}});
    issue(2'b10, 1'b1, 7'h7C, ra8f00, zero, 7'd10, {8{16'hF8F0}});
    idle(3);

    // Register mode: lane j shifted right by j+1
    issue(2'b01, 1'b0, 7'h00, ra8000, rbreg, 7'd11,
          {16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h0100, 16'h0080});
    issue(2'b10, 1'b0, 7'h00, ra8000, rbreg, 7'd12, model(2'b10, 1'b0, 7'h00, ra8000, rbreg));
    issue(2'b00, 1'b0, 7'h00, ra8001, rbreg, 7'd13, model(2'b00, 1'b0, 7'h00, ra8001, rbreg));
    idle(3);

    // Back-to-back tags 1, 2, 3 then a two-cycle stall while tag 22 waits upstream
    issue(2'b00, 1'b1, 7'h01, ra8001, zero, 7'd1, {8{16'hC000}});
    issue(2'b01, 1'b1, 7'h7F, ra8000, zero, 7'd2, {8{16'h4000}});
    drive(2'b10, 1'b1, 7'h7F, ra8000, zero, 7'd22);
    stall = 1'b1;
    @(posedge clk); #1;
    check("stall_valid_1", {127'd0, out_valid},   128'd1);
    check("stall_tag_1",   {121'd0, out_rt_addr}, 128'd1);
    @(posedge clk); #1;
    check("stall_valid_2", {127'd0, out_valid},   128'd1);
    check("stall_tag_2",   {121'd0, out_rt_addr}, 128'd1);
    stall = 1'b0;
    issue(2'b10, 1'b1, 7'h7F, ra8000, zero, 7'd22, {8{16'hC000}});
    issue(2'b01, 1'b1, 7'h70, ra8000, zero, 7'd3, {8{16'h0000}});
    idle(4);

    // Flush together with stall: both in-flight ops and the presented op die
    issue(2'b00, 1'b1, 7'h01, ra8001, zero, 7'd20, {8{16'hC000}});
    issue(2'b00, 1'b1, 7'h02, ra8001, zero, 7'd21, {8{16'h6000}});
    drive(2'b01, 1'b1, 7'h7F, ra8000, zero, 7'd23);
    stall = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_valid", {127'd0, out_valid}, 128'd0);
    sbq.delete();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    idle(4);

    // Illegal op
    issue(2'b11, 1'b1, 7'h01, ra8001, zero, 7'd30, 128'd0);
    idle(3);

    // Asynchronous reset with two ops in flight
    issue(2'b00, 1'b1, 7'h01, ra8001, zero, 7'd40, {8{16'hC000}});
    issue(2'b01, 1'b1, 7'h7F, ra8000, zero, 7'd41, {8{16'h4000}});
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid",   {127'd0, out_valid},   128'd0);
    check("arst_result",  out_result,            128'd0);
    check("arst_tag",     {121'd0, out_rt_addr}, 128'd0);
    check("arst_illegal", {127'd0, out_illegal}, 128'd0);
    sbq.delete();
    #10;
    rst = 1'b0;
    idle(4);

    // Recovery after reset
    issue(2'b00, 1'b1, 7'h01, ra8001, zero, 7'd50, {8{16'hC000}});
    idle(4);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain outstanding=%0d required=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
